// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

    // Loader FSM states, in frame order.
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        INST_LO,
        INST_HI,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    // Frame overhead: two length bytes in front, one checksum byte at the end.
    localparam int LEN_BYTES      = 2;
    localparam int CHECKSUM_BYTES = 1;

    // States in which the loader is consuming stream bytes.
    function automatic logic accepts_bytes(input loader_state_e s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == INST_LO) ||
               (s == INST_HI) || (s == CHECK);
    endfunction

    // States from which a start pulse begins a new load.
    function automatic logic is_idle_like(input loader_state_e s);
        return (s == IDLE) || (s == DONE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2**BYTE_W sum of instruction bytes with an equality compare.
module loader_checksum #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] add_data,
    input  logic [BYTE_W-1:0] cmp_data,
    output logic              match
);

    logic [BYTE_W-1:0] acc;

    // Accumulator: clear has priority; the sum wraps naturally at BYTE_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + add_data;
        end
    end

    assign match = (acc == cmp_data);

endmodule

// File: rtl/instruction_loader.sv
// Boot-time instruction-memory writer fed by a framed byte stream.
//
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready.
// byte_ready depends only on the current state, never on byte_valid, and the
// source may drop byte_valid at any time; the loader simply waits.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int INST_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int I_ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BYTE_W-1:0]   byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                imem_write_enable,
    output logic [I_ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0]   imem_write_data,
    output logic                busy,
    output logic                load_done,
    output logic                load_error,
    output logic                cpu_hold
);

    localparam int unsigned MAX_WORDS = 2 ** I_ADDR_W;
    // One extra bit so a full-size load can count to MAX_WORDS.
    localparam int CNT_W = I_ADDR_W + 1;

    loader_state_e state;
    loader_state_e state_next;

    logic                xfer;
    logic                start_load;
    logic                len_too_big;
    logic                len_zero;
    logic                last_word;
    logic                sum_match;
    logic                sum_add;
    logic [BYTE_W-1:0]   len_lo_q;
    logic [BYTE_W-1:0]   inst_lo_q;
    logic [2*BYTE_W-1:0] len_q;
    logic [2*BYTE_W-1:0] len_word;
    logic [CNT_W-1:0]    word_count;

    // Length as it is being completed by the LEN_HI byte.
    assign len_word    = {byte_data, len_lo_q};
    assign len_too_big = 32'(len_word) > MAX_WORDS;
    assign len_zero    = (len_word == '0);
    // True while the word being completed is the final one of the frame.
    assign last_word   = (32'(word_count) + 32'd1) == 32'(len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the state-decoded handshake and status outputs.
    always_comb begin
        state_next = state;
        byte_ready = accepts_bytes(state);
        busy       = accepts_bytes(state);
        xfer       = byte_valid && byte_ready;
        start_load = start && is_idle_like(state);
        sum_add    = xfer && ((state == INST_LO) || (state == INST_HI));
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    if (len_too_big) begin
                        state_next = ERROR;
                    end else if (len_zero) begin
                        state_next = CHECK;
                    end else begin
                        state_next = INST_LO;
                    end
                end
            end
            INST_LO: begin
                if (xfer) begin
                    state_next = INST_HI;
                end
            end
            INST_HI: begin
                if (xfer) begin
                    state_next = last_word ? CHECK : INST_LO;
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_next = sum_match ? DONE : ERROR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Checksum over instruction bytes only; length bytes never reach it.
    loader_checksum #(
        .BYTE_W (BYTE_W)
    ) u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_load),
        .add_en   (sum_add),
        .add_data (byte_data),
        .cmp_data (byte_data),
        .match    (sum_match)
    );

    // Frame bookkeeping: length capture, low-byte latch, word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            inst_lo_q  <= '0;
            word_count <= '0;
        end else begin
            if (start_load) begin
                word_count <= '0;
            end
            if (xfer) begin
                case (state)
                    LEN_LO:  len_lo_q   <= byte_data;
                    LEN_HI:  len_q      <= len_word;
                    INST_LO: inst_lo_q  <= byte_data;
                    INST_HI: word_count <= word_count + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Write port: one-cycle strobe after each INST_HI byte. The address is the
    // index of the word just completed, so it holds at the last address used
    // and never wraps, even for a full 2**I_ADDR_W word load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_write_enable <= 1'b0;
            imem_addr         <= '0;
            imem_write_data   <= '0;
        end else begin
            imem_write_enable <= 1'b0;
            if (start_load) begin
                imem_addr <= '0;
            end
            if (xfer && (state == INST_HI)) begin
                imem_write_enable <= 1'b1;
                imem_write_data   <= {byte_data, inst_lo_q};
                imem_addr         <= word_count[I_ADDR_W-1:0];
            end
        end
    end

    // Sticky result flags and CPU hold; only a matching checksum releases the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            if (start_load) begin
                load_done  <= 1'b0;
                load_error <= 1'b0;
                cpu_hold   <= 1'b1;
            end
            if (xfer && (state == LEN_HI) && len_too_big) begin
                load_error <= 1'b1;
            end
            if (xfer && (state == CHECK)) begin
                if (sum_match) begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end else begin
                    load_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: fixed and random frames
// compared against a frame-level reference model.
module tb_instruction_loader;

    localparam int INST_W    = 16;
    localparam int BYTE_W    = 8;
    localparam int I_ADDR_W  = 12;
    localparam int MAX_WORDS = 1 << I_ADDR_W;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic                start      = 1'b0;
    logic [BYTE_W-1:0]   byte_data  = '0;
    logic                byte_valid = 1'b0;
    logic                byte_ready;
    logic                imem_write_enable;
    logic [I_ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0]   imem_write_data;
    logic                busy;
    logic                load_done;
    logic                load_error;
    logic                cpu_hold;

    int checks   = 0;
    int failures = 0;

    // Frame under test, expected writes {addr, data}, observed writes.
    logic [7:0]  frame_q[$];
    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];
    logic        exp_ok;

    instruction_loader #(
        .INST_W   (INST_W),
        .BYTE_W   (BYTE_W),
        .I_ADDR_W (I_ADDR_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .byte_data         (byte_data),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .imem_write_enable (imem_write_enable),
        .imem_addr         (imem_addr),
        .imem_write_data   (imem_write_data),
        .busy              (busy),
        .load_done         (load_done),
        .load_error        (load_error),
        .cpu_hold          (cpu_hold)
    );

    // Clock.
    always #5 clk = ~clk;

    // Write monitor: one entry per strobe cycle.
    always @(negedge clk) begin
        if (rst_n && imem_write_enable) begin
            got_q.push_back({imem_addr, imem_write_data});
        end
    end

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: parse the frame and derive writes and the outcome.
    task automatic model_frame();
        int n;
        logic [7:0] sum;
        exp_q.delete();
        n = 32'({frame_q[1], frame_q[0]});
        if (n > MAX_WORDS) begin
            exp_ok = 1'b0;
            return;
        end
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({12'(i), frame_q[3+2*i], frame_q[2+2*i]});
            sum = sum + frame_q[2+2*i] + frame_q[3+2*i];
        end
        exp_ok = (frame_q[2+2*n] == sum);
    endtask

    // Random frame of n words, optionally with a corrupted checksum.
    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] sum;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        sum = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            sum = sum + b;
        end
        frame_q.push_back(corrupt ? sum + 8'($urandom_range(1, 255)) : sum);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Driver: optional idle gaps and stray start pulses, bounded wait for ready.
    task automatic drive_byte(input logic [7:0] b, input int gap_pct, input int start_pct);
        int waited;
        while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            start      = (start_pct > 0 && int'($urandom_range(0, 99)) < start_pct);
            @(posedge clk); #1;
            start = 1'b0;
        end
        byte_data  = b;
        byte_valid = 1'b1;
        start      = (start_pct > 0 && int'($urandom_range(0, 99)) < start_pct);
        waited     = 0;
        while (!byte_ready && waited < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            waited++;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL byte_accept got_ready=%b required=1", byte_ready);
        end else begin
            @(posedge clk); #1;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int start_pct);
        pulse_start();
        foreach (frame_q[i]) drive_byte(frame_q[i], gap_pct, start_pct);
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({byte_ready, imem_write_enable, imem_addr, imem_write_data} !== '0) begin
            failures++;
            $display("FAIL reset_port got=%b/%b/%h/%h required=0/0/000/0000",
                     byte_ready, imem_write_enable, imem_addr, imem_write_data);
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_status got=%b required=0001", {busy, load_done, load_error, cpu_hold});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, busy, cpu_hold} !== 3'b001) begin
            failures++;
            $display("FAIL idle_after_reset got=%b required=001", {byte_ready, busy, cpu_hold});
        end
    endtask

    task automatic test_nominal();
        int base;
        frame_q = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'hBD};
        model_frame();
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL nominal_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                failures++;
                $display("FAIL nominal_write[%0d] got=%h required=%h", i,
                         (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
            end
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0100) begin
            failures++;
            $display("FAIL nominal_status got=%b required=0100", {busy, load_done, load_error, cpu_hold});
        end
        checks++;
        if (imem_addr !== 12'd2 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL nominal_addr_hold got=%h/%b required=002/0", imem_addr, byte_ready);
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        frame_q = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'hBC};
        model_frame();
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL badsum_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                failures++;
                $display("FAIL badsum_write[%0d] got=%h required=%h", i,
                         (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
            end
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0011) begin
            failures++;
            $display("FAIL badsum_status got=%b required=0011", {busy, load_done, load_error, cpu_hold});
        end
    endtask

    task automatic test_empty();
        int base;
        frame_q = '{8'h00, 8'h00, 8'h01};
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0011) begin
            failures++;
            $display("FAIL empty_badsum_status got=%b required=0011", {busy, load_done, load_error, cpu_hold});
        end
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0, 0);
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0100) begin
            failures++;
            $display("FAIL empty_status got=%b required=0100", {busy, load_done, load_error, cpu_hold});
        end
        checks++;
        if (got_q.size() != base || imem_addr !== 12'd0) begin
            failures++;
            $display("FAIL empty_no_writes got=%0d/%h required=0/000", got_q.size() - base, imem_addr);
        end
    endtask

    task automatic test_oversize();
        int base;
        frame_q = '{8'h01, 8'h10};
        model_frame();
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if ({byte_ready, busy, load_done, load_error, cpu_hold} !== {1'b0, 1'b0, exp_ok, !exp_ok, 1'b1}) begin
            failures++;
            $display("FAIL oversize_status got=%b required=00011",
                     {byte_ready, busy, load_done, load_error, cpu_hold});
        end
        checks++;
        if (got_q.size() != base) begin
            failures++;
            $display("FAIL oversize_no_writes got=%0d required=0", got_q.size() - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        frame_q = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'hBD};
        model_frame();
        for (int rep = 0; rep < 3; rep++) begin
            base = got_q.size();
            send_frame(40, 20);
            checks++;
            if (got_q.size() - base != exp_q.size()) begin
                failures++;
                $display("FAIL gaps_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
            end
            foreach (exp_q[i]) begin
                checks++;
                if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL gaps_write[%0d] got=%h required=%h", i,
                             (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
                end
            end
            checks++;
            if ({busy, load_done, load_error, cpu_hold} !== 4'b0100) begin
                failures++;
                $display("FAIL gaps_status got=%b required=0100", {busy, load_done, load_error, cpu_hold});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        logic [7:0] partial_q[$];
        partial_q = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        base = got_q.size();
        pulse_start();
        foreach (partial_q[i]) drive_byte(partial_q[i], 0, 0);
        // Second word's strobe is pending right now; reset must cancel it.
        checks++;
        if (imem_write_enable !== 1'b1 || imem_addr !== 12'd1 || imem_write_data !== 16'hABCD) begin
            failures++;
            $display("FAIL midreset_pending got=%b/%h/%h required=1/001/abcd",
                     imem_write_enable, imem_addr, imem_write_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, imem_write_enable, imem_addr, imem_write_data} !== '0) begin
            failures++;
            $display("FAIL midreset_port got=%b/%b/%h/%h required=0/0/000/0000",
                     byte_ready, imem_write_enable, imem_addr, imem_write_data);
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_status got=%b required=0001", {busy, load_done, load_error, cpu_hold});
        end
        checks++;
        if (got_q.size() - base != 1) begin
            failures++;
            $display("FAIL midreset_writes got=%0d required=1", got_q.size() - base);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_q = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'hBD};
        model_frame();
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL reload_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reload_write[%0d] got=%h required=%h", i,
                         (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
            end
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== 4'b0100) begin
            failures++;
            $display("FAIL reload_status got=%b required=0100", {busy, load_done, load_error, cpu_hold});
        end
    endtask

    task automatic test_random();
        int base;
        int n;
        logic [I_ADDR_W-1:0] exp_addr;
        for (int rep = 0; rep < 8; rep++) begin
            n = int'($urandom_range(0, 24));
            build_frame(n, bit'($urandom_range(0, 1)));
            model_frame();
            exp_addr = (exp_q.size() == 0) ? '0 : I_ADDR_W'(exp_q.size() - 1);
            base = got_q.size();
            send_frame(int'($urandom_range(0, 50)), 10);
            checks++;
            if (got_q.size() - base != exp_q.size()) begin
                failures++;
                $display("FAIL random_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
            end
            foreach (exp_q[i]) begin
                checks++;
                if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_write[%0d] got=%h required=%h", i,
                             (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
                end
            end
            checks++;
            if ({busy, load_done, load_error, cpu_hold, imem_addr} !==
                {1'b0, exp_ok, !exp_ok, !exp_ok, exp_addr}) begin
                failures++;
                $display("FAIL random_status got=%b/%h required=0%b%b%b/%h",
                         {busy, load_done, load_error, cpu_hold}, imem_addr,
                         exp_ok, !exp_ok, !exp_ok, exp_addr);
            end
        end
    endtask

    task automatic test_max_len();
        int base;
        build_frame(MAX_WORDS, 1'b0);
        model_frame();
        base = got_q.size();
        send_frame(0, 0);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL maxlen_write_count got=%0d required=%0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
                failures++;
                $display("FAIL maxlen_write[%0d] got=%h required=%h", i,
                         (base + i < got_q.size()) ? got_q[base+i] : 28'hx, exp_q[i]);
            end
            checks++;
        end
        checks++;
        if ({busy, load_done, load_error, cpu_hold} !== {1'b0, exp_ok, !exp_ok, !exp_ok} ||
            imem_addr !== 12'hFFF) begin
            failures++;
            $display("FAIL maxlen_status got=%b/%h required=0100/fff",
                     {busy, load_done, load_error, cpu_hold}, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_empty();
        test_oversize();
        test_backpressure();
        test_reset_mid_load();
        test_random();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
